// File: rtl/up_axi_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : up_axi_master_pkg
// Brief    : Shared types and constants for the up-bus to AXI4-Lite master bridge.
// Revision : 1.0
// ============================================================================
package up_axi_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_ADDR = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [1:0]  C_RESP_OKAY       = 2'b00;
    localparam logic [1:0]  C_RESP_SLVERR     = 2'b10;
    localparam int          C_TIMEOUT_DEFAULT = 255;
    localparam logic [31:0] C_TIMEOUT_RDATA   = 32'hDEADDEAD;

endpackage
`default_nettype wire

// File: rtl/up_axi_master_timeout.sv
`default_nettype none
// ============================================================================
// Module   : up_axi_master_timeout
// Brief    : Response-phase watchdog; saturates at TIMEOUT_CYCLES and flags expiry.
// Revision : 1.0
// ============================================================================
module up_axi_master_timeout #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int             CW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  C_LIMIT = CW'(TIMEOUT_CYCLES);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable && (cnt_q != C_LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_expire = i_enable && (cnt_q == C_LIMIT);

endmodule
`default_nettype wire

// File: rtl/up_axi_master_bridge.sv
`default_nettype none
// ============================================================================
// Module   : up_axi_master_bridge
// Brief    : Turns single-word up-bus read/write pulses into AXI4-Lite transactions.
// Revision : 1.0
// ============================================================================
module up_axi_master_bridge
    import up_axi_master_pkg::*;
#(
    parameter int AXI_ADDRESS_WIDTH = 13,
    parameter int TIMEOUT_CYCLES    = C_TIMEOUT_DEFAULT
) (
    input  logic                         up_clk,
    input  logic                         up_rst,
    input  logic                         up_wreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0] up_waddr,
    input  logic [31:0]                  up_wdata,
    output logic                         up_wack,
    output logic                         up_werr,
    input  logic                         up_rreq,
    input  logic [AXI_ADDRESS_WIDTH-3:0] up_raddr,
    output logic                         up_rack,
    output logic                         up_rerr,
    output logic [31:0]                  up_rdata,
    output logic                         up_busy,
    output logic                         up_overrun,
    output logic                         up_stray,
    output logic                         m_axi_awvalid,
    input  logic                         m_axi_awready,
    output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_awaddr,
    output logic [2:0]                   m_axi_awprot,
    output logic                         m_axi_wvalid,
    input  logic                         m_axi_wready,
    output logic [31:0]                  m_axi_wdata,
    output logic [3:0]                   m_axi_wstrb,
    input  logic                         m_axi_bvalid,
    output logic                         m_axi_bready,
    input  logic [1:0]                   m_axi_bresp,
    output logic                         m_axi_arvalid,
    input  logic                         m_axi_arready,
    output logic [AXI_ADDRESS_WIDTH-1:0] m_axi_araddr,
    output logic [2:0]                   m_axi_arprot,
    input  logic                         m_axi_rvalid,
    output logic                         m_axi_rready,
    input  logic [31:0]                  m_axi_rdata,
    input  logic [1:0]                   m_axi_rresp
);

    localparam int AW = AXI_ADDRESS_WIDTH;

    state_e        state_q, state_d;
    logic          awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [AW-1:0] awaddr_q, awaddr_d, araddr_q, araddr_d;
    logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic          wack_q, wack_d, werr_q, werr_d, rack_q, rack_d, rerr_q, rerr_d;
    logic          overrun_q, overrun_d, stray_q, stray_d;

    logic          w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;
    logic          w_in_resp, w_expire;

    assign w_in_resp    = (state_q == ST_WR_RESP) || (state_q == ST_RD_DATA);
    // Ready is combinational from state but forced low while reset is held.
    assign m_axi_bready = !up_rst && ((state_q == ST_IDLE) || (state_q == ST_WR_RESP));
    assign m_axi_rready = !up_rst && ((state_q == ST_IDLE) || (state_q == ST_RD_DATA));

    assign w_aw_hs = awvalid_q && m_axi_awready;
    assign w_w_hs  = wvalid_q && m_axi_wready;
    assign w_ar_hs = arvalid_q && m_axi_arready;
    assign w_b_hs  = m_axi_bvalid && m_axi_bready;
    assign w_r_hs  = m_axi_rvalid && m_axi_rready;

    up_axi_master_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (up_clk),
        .rst      (up_rst),
        .i_clear  (!w_in_resp),
        .i_enable (w_in_resp),
        .o_expire (w_expire)
    );

    always_comb begin
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        overrun_d = overrun_q;
        stray_d   = stray_q;
        wack_d    = 1'b0;
        werr_d    = 1'b0;
        rack_d    = 1'b0;
        rerr_d    = 1'b0;
        rdata_d   = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (w_b_hs || w_r_hs) stray_d = 1'b1;
                if (up_wreq) begin
                    state_d   = ST_WR_ADDR;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    awaddr_d  = {up_waddr, 2'b00};
                    wdata_d   = up_wdata;
                    if (up_rreq) overrun_d = 1'b1;
                end else if (up_rreq) begin
                    state_d   = ST_RD_ADDR;
                    arvalid_d = 1'b1;
                    araddr_d  = {up_raddr, 2'b00};
                end
            end
            ST_WR_ADDR: begin
                if (w_aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || w_aw_hs) && (w_done_q || w_w_hs)) state_d = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (w_b_hs) begin
                    state_d = ST_DONE;
                    wack_d  = 1'b1;
                    werr_d  = (m_axi_bresp != C_RESP_OKAY);
                end else if (w_expire) begin
                    state_d = ST_DONE;
                    wack_d  = 1'b1;
                    werr_d  = 1'b1;
                end
            end
            ST_RD_ADDR: begin
                if (w_ar_hs) begin
                    arvalid_d = 1'b0;
                    state_d   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (w_r_hs) begin
                    state_d = ST_DONE;
                    rack_d  = 1'b1;
                    rdata_d = m_axi_rdata;
                    rerr_d  = (m_axi_rresp != C_RESP_OKAY);
                end else if (w_expire) begin
                    state_d = ST_DONE;
                    rack_d  = 1'b1;
                    rdata_d = C_TIMEOUT_RDATA;
                    rerr_d  = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if ((state_q != ST_IDLE) && (up_wreq || up_rreq)) overrun_d = 1'b1;
    end

    always_ff @(posedge up_clk) begin
        if (up_rst) begin
            state_q   <= ST_IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            wack_q    <= 1'b0;
            werr_q    <= 1'b0;
            rack_q    <= 1'b0;
            rerr_q    <= 1'b0;
            overrun_q <= 1'b0;
            stray_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            wack_q    <= wack_d;
            werr_q    <= werr_d;
            rack_q    <= rack_d;
            rerr_q    <= rerr_d;
            overrun_q <= overrun_d;
            stray_q   <= stray_d;
        end
    end

    assign up_wack       = wack_q;
    assign up_werr       = werr_q;
    assign up_rack       = rack_q;
    assign up_rerr       = rerr_q;
    assign up_rdata      = rdata_q;
    assign up_busy       = (state_q != ST_IDLE);
    assign up_overrun    = overrun_q;
    assign up_stray      = stray_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;

endmodule
`default_nettype wire

// File: doc/up_axi_master_bridge.md
UP_AXI_MASTER_BRIDGE -- requirements
Module: up_axi_master_bridge

Interface
REQ-001 SHALL have parameter AXI_ADDRESS_WIDTH, default 13, AXI byte-address width; up word address is AXI_ADDRESS_WIDTH-2 bits.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, response-phase timeout in up_clk cycles, range 1..65535.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 up_clk  input  1  sole clock.
REQ-005 up_rst  input  1  synchronous active-high reset.
REQ-006 up_wreq, up_waddr[AW-3:0], up_wdata[31:0]  input  write request pulse, word address, data.
REQ-007 up_wack, up_werr  output  1  write completion pulse; error qualifier.
REQ-008 up_rreq, up_raddr[AW-3:0]  input  read request pulse, word address.
REQ-009 up_rack, up_rerr  output  1  read completion pulse; error qualifier. up_rdata  output  32  read data.
REQ-010 up_busy  output  1  transaction in flight. up_overrun, up_stray  output  1  sticky status.
REQ-011 m_axi_aw*/w*/b*/ar*/r*  AXI4-Lite master port: awvalid/awready/awaddr/awprot, wvalid/wready/wdata/wstrb, bvalid/bready/bresp, arvalid/arready/araddr/arprot, rvalid/rready/rdata/rresp.

Function
REQ-012 States: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA, DONE.
REQ-013 A request is accepted only in IDLE; simultaneous up_wreq and up_rreq: write served, read dropped, up_overrun set.
REQ-014 Any up_wreq/up_rreq outside IDLE is dropped and sets up_overrun (sticky until reset).
REQ-015 Accepted write in cycle 0: awvalid=wvalid=1 from cycle 1; awaddr={up_waddr,2'b00}; wstrb=4'hF; awprot=arprot=3'b000.
REQ-016 awvalid and wvalid each drop the cycle after their own handshake; WR_RESP entered when both handshakes done (same or different cycles).
REQ-017 Accepted read: arvalid=1 from cycle 1, araddr={up_raddr,2'b00}; drops after handshake; enter RD_DATA.
REQ-018 Address phases wait indefinitely (valid never withdrawn); timeout counter runs only in WR_RESP/RD_DATA, cleared on entry.
REQ-019 bready=1 in WR_RESP and IDLE; rready=1 in RD_DATA and IDLE; 0 elsewhere.
REQ-020 bvalid handshake in cycle N: up_wack=1 in cycle N+1 for exactly one cycle, up_werr=(bresp!=2'b00).
REQ-021 rvalid handshake in cycle N: up_rack=1 in cycle N+1, up_rdata=rdata, up_rerr=(rresp!=2'b00).
REQ-022 up_rdata SHALL be 32'h0 in every cycle where up_rack=0 (OR-bus compatible).
REQ-023 Timeout (counter reaches TIMEOUT_CYCLES with no response): ack with err=1; reads return 32'hDEADDEAD.
REQ-024 bvalid/rvalid handshake in IDLE (late response) is discarded and sets up_stray (sticky).
REQ-025 DONE lasts one cycle (ack cycle), then IDLE; next request accepted the cycle after DONE.
REQ-026 up_busy=1 in every state except IDLE.

Reset
REQ-027 On up_rst: state IDLE, all valid outputs 0, bready/rready 0, up_wack/up_rack/up_werr/up_rerr 0, up_rdata 0, up_overrun/up_stray 0, counter 0, addresses/wdata 0.
REQ-028 Reset mid-transaction aborts without ack; AXI valids drop the cycle after reset asserts.

Structure
REQ-029 Shared package up_axi_master_pkg SHALL hold state enum, AXI resp codes (OKAY=2'b00), TIMEOUT default, 32'hDEADDEAD constant.
REQ-030 Timeout counter SHALL be sub-module up_axi_master_timeout (clear, enable, expire), width $clog2(TIMEOUT_CYCLES+1).

Verification
REQ-031 Write waddr=11'h010, data=32'hA5A5_0001, awready+wready same cycle, bresp=0 -> awaddr=13'h0040, one up_wack, up_werr=0.
REQ-032 Write with wready 3 cycles after awready, bresp=2'b10 -> WR_RESP only after both handshakes, up_wack with up_werr=1.
REQ-033 Read raddr=11'h001, rdata=32'h1234_5678 after 5-cycle rvalid delay -> araddr=13'h0004, up_rack with up_rdata=32'h1234_5678, up_rdata=0 all other cycles.
REQ-034 Read, no rvalid, TIMEOUT_CYCLES=16 -> up_rack, up_rerr=1, up_rdata=32'hDEADDEAD; later rvalid in IDLE sets up_stray.
REQ-035 up_wreq+up_rreq same cycle, then up_wreq while busy -> one write only, up_overrun=1, read never issued.
REQ-036 up_rst asserted while arvalid pending -> arvalid 0 next cycle, no up_rack, all outputs at reset values.
